// File: rtl/slsr_serializer.sv
// Parallel-to-serial transmitter for the slsr shift register: one word in via
// valid/ready, WIDTH data bits out on dout, each qualified by exactly one sl or sr strobe.
module slsr_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load_valid,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_load_dir,
    output logic             o_load_ready,
    input  logic             i_hold,
    output logic             o_dout,
    output logic             o_sl,
    output logic             o_sr,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    // Handshake: a word transfers at a rising edge where i_load_valid and
    // o_load_ready are both 1; i_load_data/i_load_dir are sampled only then.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_dir;
    logic [CW-1:0]    r_sent;
    logic             r_load_ready;
    logic             r_dout;
    logic             r_sl;
    logic             r_sr;
    logic             r_busy;
    logic             r_done;

    logic             w_next_bit;
    logic             w_all_sent;

    // MSB leaves first when shifting left, LSB first when shifting right.
    assign w_next_bit = r_dir ? r_shift[0] : r_shift[WIDTH-1];
    assign w_all_sent = (r_sent == CW'(WIDTH));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_dir        <= 1'b0;
            r_sent       <= '0;
            r_load_ready <= 1'b1;
            r_dout       <= 1'b0;
            r_sl         <= 1'b0;
            r_sr         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sl   <= 1'b0;
                    r_sr   <= 1'b0;
                    r_done <= 1'b0;
                    if (i_load_valid && r_load_ready) begin
                        r_state      <= ST_SHIFT;
                        r_shift      <= i_load_data;
                        r_dir        <= i_load_dir;
                        r_sent       <= '0;
                        r_load_ready <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_all_sent) begin
                        // Hold is deliberately ignored here: the word is complete.
                        r_state <= ST_DONE;
                        r_sl    <= 1'b0;
                        r_sr    <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (i_hold) begin
                        r_sl <= 1'b0;
                        r_sr <= 1'b0;
                    end else begin
                        r_dout  <= w_next_bit;
                        r_sl    <= ~r_dir;
                        r_sr    <= r_dir;
                        r_sent  <= r_sent + CW'(1);
                        r_shift <= r_dir ? (r_shift >> 1) : (r_shift << 1);
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_done       <= 1'b0;
                    r_busy       <= 1'b0;
                    r_load_ready <= 1'b1;
                    r_sl         <= 1'b0;
                    r_sr         <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_load_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_sl         <= 1'b0;
                    r_sr         <= 1'b0;
                end
            endcase
        end
    end

    assign o_load_ready = r_load_ready;
    assign o_dout       = r_dout;
    assign o_sl         = r_sl;
    assign o_sr         = r_sr;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_state      = r_state;

endmodule

// File: tb/tb_slsr_serializer.sv
// Directed bench for slsr_serializer: drives words through the handshake and
// rebuilds them in a behavioural slsr receiver fed by dout/sl/sr.
module tb_slsr_serializer;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_load_valid;
    logic [W-1:0] i_load_data;
    logic         i_load_dir;
    logic         o_load_ready;
    logic         i_hold;
    logic         o_dout;
    logic         o_sl;
    logic         o_sr;
    logic         o_busy;
    logic         o_done;
    logic [1:0]   o_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] rx_q;

    slsr_serializer #(.WIDTH(W)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load_valid (i_load_valid),
        .i_load_data  (i_load_data),
        .i_load_dir   (i_load_dir),
        .o_load_ready (o_load_ready),
        .i_hold       (i_hold),
        .o_dout       (o_dout),
        .o_sl         (o_sl),
        .o_sr         (o_sr),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Receiver: the downstream slsr, reset together with the serializer.
    always @(posedge i_clk) begin
        if (i_reset)   rx_q <= '0;
        else if (o_sl) rx_q <= {rx_q[W-2:0], o_dout};
        else if (o_sr) rx_q <= {o_dout, rx_q[W-1:1]};
    end

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, o_load_ready, 1);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_dout"},  o_dout, 0);
        chk({tag, "_sl"},    o_sl, 0);
        chk({tag, "_sr"},    o_sr, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_state"}, o_state, 0);
    endtask

    // Sends one word. seq holds the bits in transmission order, seq[7] first.
    // Hold is raised for hold_len edges once hold_at strobes have been seen.
    // When keep_valid is set, valid stays high with next_data after the accept.
    task automatic run_word(input string tag, input logic [W-1:0] d, input logic dir,
                            input logic [W-1:0] seq, input int hold_at, input int hold_len,
                            input int exp_done_cyc, input logic keep_valid,
                            input logic [W-1:0] next_data);
        int   strobes = 0;
        int   held = 0;
        int   cyc = 0;
        int   done_cyc = -1;
        logic prev_dout;
        logic was_hold;
        i_load_valid = 1'b1;
        i_load_data  = d;
        i_load_dir   = dir;
        chk({tag, "_ready_pre"}, o_load_ready, 1);
        step();
        if (keep_valid) i_load_data = next_data;
        else            i_load_valid = 1'b0;
        i_load_dir = ~dir;
        chk({tag, "_busy_acc"}, o_busy, 1);
        chk({tag, "_ready_acc"}, o_load_ready, 0);
        chk({tag, "_nostrobe_acc"}, {o_sl, o_sr}, 0);
        chk({tag, "_state_acc"}, o_state, 1);
        while (cyc < 40 && done_cyc < 0) begin
            was_hold = (hold_len > 0) && (strobes == hold_at) && (held < hold_len);
            if (was_hold) held++;
            i_hold    = was_hold;
            prev_dout = o_dout;
            step();
            cyc++;
            i_hold = 1'b0;
            chk({tag, "_excl"}, o_sl & o_sr, 0);
            if (was_hold) begin
                chk({tag, "_hold_nostrobe"}, {o_sl, o_sr}, 0);
                chk({tag, "_hold_dout"}, o_dout, prev_dout);
            end
            if (o_sl || o_sr) begin
                chk({tag, "_dir"}, {o_sl, o_sr}, dir ? 2'b01 : 2'b10);
                if (strobes < W) chk({tag, "_bit"}, o_dout, seq[W-1-strobes]);
                strobes++;
            end
            if (o_done) done_cyc = cyc;
        end
        chk({tag, "_done_cyc"}, done_cyc, exp_done_cyc);
        chk({tag, "_strobes"}, strobes, W);
        chk({tag, "_rx_q"}, rx_q, d);
        chk({tag, "_busy_done"}, o_busy, 1);
        chk({tag, "_state_done"}, o_state, 2);
        step();
        chk({tag, "_done_pulse"}, o_done, 0);
        chk({tag, "_ready_post"}, o_load_ready, 1);
        chk({tag, "_busy_post"}, o_busy, 0);
    endtask

    initial begin
        int strobes;
        int cyc;
        i_reset      = 1'b1;
        i_load_valid = 1'b1;
        i_load_data  = 8'hFF;
        i_load_dir   = 1'b0;
        i_hold       = 1'b0;
        step();
        step();
        chk_idle("rst");
        i_reset      = 1'b0;
        i_load_valid = 1'b0;
        step();
        chk_idle("rst_after");

        run_word("a5_left", 8'hA5, 1'b0, 8'b10100101, 8, 0, 9, 1'b0, 8'h00);
        run_word("3c_right", 8'h3C, 1'b1, 8'b00111100, 8, 0, 9, 1'b0, 8'h00);
        run_word("f0_hold", 8'hF0, 1'b0, 8'b11110000, 4, 3, 12, 1'b0, 8'h00);

        // Abort a word after its 3rd strobe; everything returns to reset values.
        i_load_valid = 1'b1;
        i_load_data  = 8'hFF;
        i_load_dir   = 1'b0;
        step();
        i_load_valid = 1'b0;
        strobes = 0;
        cyc = 0;
        while (strobes < 3 && cyc < 20) begin
            step();
            cyc++;
            if (o_sl || o_sr) strobes++;
        end
        chk("abort_strobes", strobes, 3);
        i_reset = 1'b1;
        step();
        chk_idle("abort");
        chk("abort_rx_q", rx_q, 0);
        i_reset = 1'b0;
        run_word("81_resend", 8'h81, 1'b0, 8'b10000001, 8, 0, 9, 1'b0, 8'h00);

        // Valid held high; data changes to 8'h22 while the first word is busy.
        run_word("11_first", 8'h11, 1'b0, 8'b00010001, 8, 0, 9, 1'b1, 8'h22);
        run_word("22_next", 8'h22, 1'b0, 8'b00100010, 8, 0, 9, 1'b0, 8'h00);

        // Hold in IDLE has no effect on the outputs.
        i_hold = 1'b1;
        step();
        i_hold = 1'b0;
        chk_idle("idle_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/slsr_serializer.md
Name: slsr_serializer

Overview:
- Parallel-to-serial transmitter that feeds the slsr shift register from the opposite end of its serial interface.
- Accepts one WIDTH-bit word through a valid/ready handshake and drives dout plus exactly one shift strobe (sl or sr) per bit.
- After a complete word, the downstream slsr's Q equals the loaded word.
- Sits between a word-level producer and the slsr serial inputs (din, sl, sr).

Parameters:
WIDTH, 8, word width and number of shift strobes per word; must be >= 2.

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  producer has a word on load_data
load_data  input  WIDTH  word to serialize
load_dir  input  1  0 = shift-left (MSB first, drives sl); 1 = shift-right (LSB first, drives sr)
load_ready  output  1  block can accept a word this cycle
hold  input  1  stall request; suppresses the next strobe
dout  output  1  serial data, connects to slsr din
sl  output  1  shift-left strobe, connects to slsr sl
sr  output  1  shift-right strobe, connects to slsr sr
busy  output  1  word in progress (SHIFT or DONE)
done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- Reset: synchronous, active-high; takes effect at the next clk edge and overrides all other inputs.
- All outputs are registered.
- Reset values: load_ready=1, dout=0, sl=0, sr=0, busy=0, done=0, state=IDLE, sent count=0.
- States:
  - IDLE: load_ready=1, busy=0, strobes 0.
  - SHIFT: load_ready=0, busy=1.
  - DONE: done=1, busy=1, load_ready=0, strobes 0.
- IDLE -> SHIFT: at an edge with load_valid=1 and load_ready=1. load_data and load_dir are captured into shift and direction registers; sent=0. First cycle in SHIFT presents no strobe.
- SHIFT, at each edge while sent<WIDTH:
  - hold=0: next cycle dout = next bit (MSB-first if dir=0, LSB-first if dir=1); sl=~dir, sr=dir; sent increments.
  - hold=1: next cycle sl=sr=0; dout keeps its value; sent unchanged.
- SHIFT -> DONE: at the edge where sent==WIDTH; hold is ignored at this edge. Strobes drop to 0; done=1 for exactly one cycle.
- DONE -> IDLE: unconditionally at the next edge.
- Timing without hold (accept at edge E0):
  - Strobe cycles follow E1..E_WIDTH; the receiver samples on E2..E_WIDTH+1.
  - done high after E_WIDTH+1.
  - load_ready high after E_WIDTH+2.
  - Minimum period WIDTH+3 cycles per word.
- Invariants:
  - sl and sr are never both 1.
  - Exactly WIDTH strobe cycles per word; no bit dropped or duplicated regardless of hold pattern.
  - dir is fixed for the whole word.
- load_valid while busy=1: ignored; no data captured. The producer must keep load_valid asserted until the accept edge.
- load_dir and load_data are sampled only at the accept edge; later changes have no effect.
- Reset mid-word: the next cycle shows reset values and the partial word is discarded. The downstream register holds a partial shift, and the producer re-sends.
- hold in IDLE or DONE: no effect.
- sent counter width: clog2(WIDTH+1) bits; no wrap-around.

Test Plan:
- Reset held 2 cycles with load_valid=1 and load_data=8'hFF -> load_ready=1, busy=0, dout=sl=sr=done=0; no word accepted.
- Accept 8'hA5, dir=0, hold=0 -> sl=1 for exactly 8 consecutive cycles with dout 1,0,1,0,0,1,0,1. A bench slsr model ends with Q=8'hA5. done high one cycle after E9; load_ready=1 after E10; sr stays 0 throughout.
- Accept 8'h3C, dir=1 -> sr=1 for 8 cycles with dout 0,0,1,1,1,1,0,0. Model Q=8'h3C; sl stays 0.
- Accept 8'hF0, dir=0, hold=1 for 3 edges after the 4th strobe -> sl low for 3 cycles with dout steady. Exactly 8 strobe cycles total; model Q=8'hF0; done arrives 3 cycles later than the no-hold case.
- Accept 8'hFF, reset pulsed after the 3rd strobe -> next cycle all outputs at reset values. Then accept 8'h81, dir=0 -> 8 clean strobes; model (reset together with the DUT) Q=8'h81.
- load_valid held high with 8'h11 then 8'h22 changing while busy -> only 8'h11 is serialized. 8'h22 is accepted at the first edge with load_ready=1 and serialized as the next word.
